ps2_keyboard_rx: RTL and testbench

//   PS/2 keyboard receiver: the producer side of the keyboard port that Memory exposes at address 0x76000.

---
 rtl/ps2_keyboard_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 pins,
// deserialises 11-bit frames and strips E0/F0 prefixes into make-code strobes.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       key_ext,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  state_e        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic          brk_q, ext_q;
  logic [TW-1:0] to_q;
  logic [7:0]    key_q;
  logic          key_ext_q;
  logic          sample_q;
  logic          frame_err_q;

  // Two-flop synchronisers; both pins idle high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: level flips after FILTER_LEN disagreeing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filtered clock level and run-length counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM, timeout watchdog and prefix decode with registered strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      to_q        <= '0;
      key_q       <= '0;
      key_ext_q   <= 1'b0;
      sample_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sample_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        to_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q  <= {dat_s2_q, shreg_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (dat_s2_q && (^shreg_q ^ par_q)) begin
              if (shreg_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else if (shreg_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (brk_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
              end else begin
                key_q     <= shreg_q;
                key_ext_q <= ext_q;
                sample_q  <= 1'b1;
                ext_q     <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              brk_q       <= 1'b0;
              ext_q       <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= IDLE;
          to_q        <= '0;
          frame_err_q <= 1'b1;
          brk_q       <= 1'b0;
          ext_q       <= 1'b0;
        end else begin
          to_q <= to_q + 1'b1;
        end
      end
    end
  end

  assign key_reg   = key_q;
  assign key_ext   = key_ext_q;
  assign sample    = sample_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames push expected
// strobes; a monitor pops and compares on every sample/frame_err.
module tb_ps2_keyboard_rx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_reg;
  logic       sample, key_ext, frame_err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         err;
    logic [7:0] key;
    logic       ext;
  } exp_t;

  exp_t sb[$];

  ps2_keyboard_rx #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_reg  (key_reg),
    .sample   (sample),
    .key_ext  (key_ext),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_key(input logic [7:0] k, input logic e);
    exp_t x;
    x.err = 1'b0;
    x.key = k;
    x.ext = e;
    sb.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.err = 1'b1;
    x.key = 8'h00;
    x.ext = 1'b0;
    sb.push_back(x);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(50);
    ps2_clk = 1'b0;
    wait_cyc(50);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    ps2_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(150);
  endtask

  logic prev_s = 1'b0;
  logic prev_e = 1'b0;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n) begin
      if (sample && frame_err) begin
        checks++;
        errors++;
        $display("FAIL both_strobes sample=1 frame_err=1");
      end else if (sample || frame_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe sample=%0b frame_err=%0b key=%h",
                   sample, frame_err, key_reg);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.err != frame_err ||
              (!e.err && (key_reg !== e.key || key_ext !== e.ext))) begin
            errors++;
            $display("FAIL strobe got err=%0b key=%h ext=%0b exp err=%0b key=%h ext=%0b",
                     frame_err, key_reg, key_ext, e.err, e.key, e.ext);
          end
        end
      end
      if ((sample && prev_s) || (frame_err && prev_e)) begin
        checks++;
        errors++;
        $display("FAIL strobe_width sample=%0b frame_err=%0b exp 1-cycle",
                 sample, frame_err);
      end
    end
    prev_s = sample & reset_n;
    prev_e = frame_err & reset_n;
  end

  initial begin
    logic busy_seen;

    wait_cyc(3);
    chk("rst_key", key_reg, 8'h00);
    chk("rst_sample", {7'd0, sample}, 8'h00);
    chk("rst_ext", {7'd0, key_ext}, 8'h00);
    chk("rst_err", {7'd0, frame_err}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset_n = 1'b1;
    wait_cyc(20);

    // 1. plain make code
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("s1_key", key_reg, 8'h1C);
    chk("s1_ext", {7'd0, key_ext}, 8'h00);
    chk("s1_busy", {7'd0, busy}, 8'h00);

    // 2. break sequence is swallowed
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("s2_key", key_reg, 8'h1C);

    // 3. extended make, then a plain one clears ext
    send_frame(8'hE0, 1'b0, 1'b1);
    push_key(8'h75, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("s3_key", key_reg, 8'h75);
    chk("s3_ext", {7'd0, key_ext}, 8'h01);
    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("s3_ext_clr", {7'd0, key_ext}, 8'h00);

    // 4. bad parity, bad stop
    push_err();
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("s4_par_key", key_reg, 8'h1C);
    push_err();
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("s4_stop_key", key_reg, 8'h1C);
    chk("s4_busy", {7'd0, busy}, 8'h00);

    // 5. timeout after start + 3 data bits, then recovery
    push_err();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    chk("s5_busy_mid", {7'd0, busy}, 8'h01);
    wait_cyc(1100);
    chk("s5_busy", {7'd0, busy}, 8'h00);
    chk("s5_key", key_reg, 8'h1C);
    push_key(8'h29, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("s5_rec_key", key_reg, 8'h29);

    // 6. reset mid-frame after 5 data bits of 0x1C
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    wait_cyc(10);
    chk("s6_busy_pre", {7'd0, busy}, 8'h01);
    reset_n = 1'b0;
    #1;
    chk("s6_key", key_reg, 8'h00);
    chk("s6_ext", {7'd0, key_ext}, 8'h00);
    chk("s6_sample", {7'd0, sample}, 8'h00);
    chk("s6_err", {7'd0, frame_err}, 8'h00);
    chk("s6_busy", {7'd0, busy}, 8'h00);
    wait_cyc(5);
    ps2_data = 1'b1;
    reset_n = 1'b1;
    wait_cyc(20);

    // glitch on ps2_clk must not start a frame
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wait_cyc(1);
      busy_seen = busy_seen | busy;
    end
    chk("s6_glitch_busy", {7'd0, busy_seen}, 8'h00);

    push_key(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("s6_key_after", key_reg, 8'h1C);
    chk("s6_ext_after", {7'd0, key_ext}, 8'h00);

    wait_cyc(50);
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
